// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared definitions for the multicycle controller:
//   - state_t      : 4-bit main FSM state encoding
//   - ALU_*        : ALUControl operation codes
//   - OP_*         : instruction class (Op field)
//   - COND_*       : condition field codes
//   - CMD_*        : data-processing command codes (Funct[4:1])
//   - cond_check() : evaluates a condition field against {N,Z,C,V}
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // flags ordered {N,Z,C,V}
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        logic res;
        {n, z, c, v} = flags;
        res = 1'b0;
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;   // NV never executes
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_condlogic.sv
// mc_condlogic
// Flag register, condition evaluation and write-enable gating.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   cond            : instruction condition field
//   alu_flags       : {N,Z,C,V} from the ALU this cycle
//   flag_w          : [1] update {N,Z}, [0] update {C,V} (only nonzero in EXEC)
//   cond_latch      : high in DECODE; captures the condition result
//   fetch           : FSM is in FETCH
//   branch, reg_w,
//   mem_w, rd_is_pc : raw controls from the FSM / instruction decode
//   pc_write, reg_write, mem_write : gated datapath enables
module mc_condlogic
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       cond_latch,
    input  logic       fetch,
    input  logic       branch,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       rd_is_pc,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write
);

    logic [3:0] flags_reg;
    logic       cond_ex_reg;
    logic       pcs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_reg   <= 4'b0000;
            cond_ex_reg <= 1'b0;
        end else begin
            // Condition is frozen in DECODE so flag writes later in the same
            // instruction cannot change whether it executes.
            if (cond_latch)
                cond_ex_reg <= cond_check(cond, flags_reg);
            if (flag_w[1] && cond_ex_reg)
                flags_reg[3:2] <= alu_flags[3:2];
            if (flag_w[0] && cond_ex_reg)
                flags_reg[1:0] <= alu_flags[1:0];
        end
    end

    // A register write targeting R15 becomes a PC write instead.
    assign pcs       = branch | (reg_w & rd_is_pc);
    assign pc_write  = (fetch & reset) | (pcs & cond_ex_reg);
    assign reg_write = reg_w & cond_ex_reg & ~rd_is_pc;
    assign mem_write = mem_w & cond_ex_reg;

endmodule

// File: rtl/mc_controller.sv
// mc_controller
// Multicycle ARM-subset control unit: main FSM, ALU decoder and instruction
// decoder; condition/flag handling lives in mc_condlogic.
// Parameter: ALUCTRL_W (2 or 3); EOR is only decoded when 3.
// Optional feature: define MC_CTRL_STATE_OUT_EN to expose the FSM state on
// output State[3:0].
// Ports:
//   clk, reset (async active-low), Instr[19:0] = instruction bits [31:12],
//   ALUFlags {N,Z,C,V};
//   outputs PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
//   RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl [, State].
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [19:0]          Instr,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           RegSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [ALUCTRL_W-1:0] ALUControl
`ifdef MC_CTRL_STATE_OUT_EN
    ,
    output logic [3:0]           State
`endif
);

    // Instruction fields (Instr[19:0] holds bits 31:12)
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    assign cond  = Instr[19:16];
    assign op    = Instr[15:14];
    assign funct = Instr[13:8];
    assign rd    = Instr[3:0];

    state_t state_reg, state_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= S_FETCH;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_next = S_MEMADR;
                    OP_DP:   state_next = funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_next = S_BRANCH;
                    default: state_next = S_UNKNOWN;
                endcase
            end
            S_MEMADR: state_next = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_next = S_ALUWB;
            default:  state_next = S_FETCH;
        endcase
    end

    // ALU decoder: unsupported commands fall back to ADD and are flagged
    // invalid so that neither the register file nor the flags are touched.
    logic [2:0] alu_dec;
    logic       dec_valid;
    logic       is_cmp;
    logic       is_arith;
    logic [1:0] flag_w_dec;

    always_comb begin
        alu_dec   = ALU_ADD;
        dec_valid = 1'b1;
        is_cmp    = 1'b0;
        is_arith  = 1'b0;
        case (funct[4:1])
            CMD_ADD: begin alu_dec = ALU_ADD; is_arith = 1'b1; end
            CMD_SUB: begin alu_dec = ALU_SUB; is_arith = 1'b1; end
            CMD_AND: alu_dec = ALU_AND;
            CMD_ORR: alu_dec = ALU_ORR;
            CMD_CMP: begin alu_dec = ALU_SUB; is_arith = 1'b1; is_cmp = 1'b1; end
            CMD_EOR: begin
                if (ALUCTRL_W == 3)
                    alu_dec = ALU_EOR;
                else
                    dec_valid = 1'b0;
            end
            default: dec_valid = 1'b0;
        endcase
        flag_w_dec = 2'b00;
        if (dec_valid && (funct[0] || is_cmp))
            flag_w_dec = is_arith ? 2'b11 : 2'b10;
    end

    // State-dependent control outputs
    logic [2:0] alu_ctrl;
    logic [1:0] flag_w;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       fetch;

    always_comb begin
        fetch     = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        alu_ctrl  = ALU_ADD;
        flag_w    = 2'b00;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                fetch     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECR: begin
                alu_ctrl = alu_dec;
                flag_w   = flag_w_dec;
            end
            S_EXECI: begin
                ALUSrcB  = 2'b01;
                alu_ctrl = alu_dec;
                flag_w   = flag_w_dec;
            end
            S_ALUWB:  reg_w = dec_valid & ~is_cmp;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign IRWrite    = fetch & reset;
    assign ALUControl = alu_ctrl[ALUCTRL_W-1:0];
    assign ImmSrc     = op;
    assign RegSrc     = {op == OP_MEM, op == OP_BR};

    mc_condlogic u_condlogic (
        .clk        (clk),
        .reset      (reset),
        .cond       (cond),
        .alu_flags  (ALUFlags),
        .flag_w     (flag_w),
        .cond_latch (state_reg == S_DECODE),
        .fetch      (fetch),
        .branch     (branch),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .rd_is_pc   (rd == 4'hF),
        .pc_write   (PCWrite),
        .reg_write  (RegWrite),
        .mem_write  (MemWrite)
    );

`ifdef MC_CTRL_STATE_OUT_EN
    assign State = state_reg;
`endif

    // Rn is decoded by the datapath; the top ALU bit is dropped when ALUCTRL_W=2.
    logic unused_bits;
    assign unused_bits = ^{Instr[7:4], alu_ctrl};

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    logic        clk;
    logic        reset;
    logic [19:0] instr;
    logic [3:0]  flags;

    logic       pcw3, irw3, rw3, mw3, adr3, asa3;
    logic [1:0] rsrc3, imm3, asb3, res3;
    logic [2:0] alu3;
    logic       pcw2, irw2, rw2, mw2, adr2, asa2;
    logic [1:0] rsrc2, imm2, asb2, res2;
    logic [1:0] alu2;

    mc_controller #(.ALUCTRL_W(3)) dut3 (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(flags),
        .PCWrite(pcw3), .IRWrite(irw3), .RegWrite(rw3), .MemWrite(mw3),
        .AdrSrc(adr3), .ALUSrcA(asa3), .RegSrc(rsrc3), .ImmSrc(imm3),
        .ALUSrcB(asb3), .ResultSrc(res3), .ALUControl(alu3)
    );

    mc_controller #(.ALUCTRL_W(2)) dut2 (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(flags),
        .PCWrite(pcw2), .IRWrite(irw2), .RegWrite(rw2), .MemWrite(mw2),
        .AdrSrc(adr2), .ALUSrcA(asa2), .RegSrc(rsrc2), .ImmSrc(imm2),
        .ALUSrcB(asb2), .ResultSrc(res2), .ALUControl(alu2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCW, IRW, RW, MW, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUCtl[2:0], ImmSrc, RegSrc}
    logic [16:0] v3, v2;
    assign v3 = {pcw3, irw3, rw3, mw3, adr3, asa3, asb3, res3, alu3, imm3, rsrc3};
    assign v2 = {pcw2, irw2, rw2, mw2, adr2, asa2, asb2, res2, 1'b0, alu2, imm2, rsrc2};

    typedef struct {
        logic [19:0] instr;
        logic [3:0]  flags;
        logic [16:0] e3;
        logic [16:0] e2;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [16:0] mk(input logic pcw, input logic irw, input logic rw,
                                       input logic mw, input logic adr, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] rs,
                                       input logic [2:0] alu, input logic [1:0] imm,
                                       input logic [1:0] rsrc);
        return {pcw, irw, rw, mw, adr, asa, asb, rs, alu, imm, rsrc};
    endfunction

    task automatic add(input logic [19:0] i, input logic [3:0] f,
                       input logic [16:0] e3, input logic [16:0] e2);
        vec_t v;
        v.instr = i; v.flags = f; v.e3 = e3; v.e2 = e2;
        vecs.push_back(v);
    endtask

    task automatic add1(input logic [19:0] i, input logic [3:0] f, input logic [16:0] e);
        add(i, f, e, e);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [16:0] act, input logic [16:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %05h want %05h", name, idx, act, exp);
        end else begin
            $display("ok   %s[%0d]: %05h", name, idx, act);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end else begin
            $display("ok   %s: %0b", name, act);
        end
    endtask

    initial begin
        // ADD R1,R2,R3 (AL)
        add1(20'hE0821, 4'h0, mk(1,1,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hE0821, 4'h0, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hE0821, 4'h0, mk(0,0,0,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0));
        add1(20'hE0821, 4'h0, mk(0,0,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0));
        // LDR R0,[R1,#4]
        add1(20'hE5910, 4'h0, mk(1,1,0,0,0,1,2'd2,2'd2,3'd0,2'd1,2'd2));
        add1(20'hE5910, 4'h0, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd1,2'd2));
        add1(20'hE5910, 4'h0, mk(0,0,0,0,0,0,2'd1,2'd0,3'd0,2'd1,2'd2));
        add1(20'hE5910, 4'h0, mk(0,0,0,0,1,0,2'd0,2'd0,3'd0,2'd1,2'd2));
        add1(20'hE5910, 4'h0, mk(0,0,1,0,0,0,2'd0,2'd1,3'd0,2'd1,2'd2));
        // SUBS with Z=1 result
        add1(20'hE0500, 4'h0, mk(1,1,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hE0500, 4'h0, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hE0500, 4'h4, mk(0,0,0,0,0,0,2'd0,2'd0,3'd1,2'd0,2'd0));
        add1(20'hE0500, 4'h0, mk(0,0,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0));
        // BEQ taken
        add1(20'h0A000, 4'h0, mk(1,1,0,0,0,1,2'd2,2'd2,3'd0,2'd2,2'd1));
        add1(20'h0A000, 4'h0, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd2,2'd1));
        add1(20'h0A000, 4'h0, mk(1,0,0,0,0,0,2'd1,2'd2,3'd0,2'd2,2'd1));
        // SUBS with Z=0 result
        add1(20'hE0500, 4'h0, mk(1,1,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hE0500, 4'h0, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hE0500, 4'h0, mk(0,0,0,0,0,0,2'd0,2'd0,3'd1,2'd0,2'd0));
        add1(20'hE0500, 4'h0, mk(0,0,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0));
        // BEQ not taken
        add1(20'h0A000, 4'h0, mk(1,1,0,0,0,1,2'd2,2'd2,3'd0,2'd2,2'd1));
        add1(20'h0A000, 4'h0, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd2,2'd1));
        add1(20'h0A000, 4'h0, mk(0,0,0,0,0,0,2'd1,2'd2,3'd0,2'd2,2'd1));
        // CMP sets Z=1, no register write
        add1(20'hE1500, 4'h0, mk(1,1,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hE1500, 4'h0, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hE1500, 4'h4, mk(0,0,0,0,0,0,2'd0,2'd0,3'd1,2'd0,2'd0));
        add1(20'hE1500, 4'h0, mk(0,0,0,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0));
        // STRNE suppressed (Z=1)
        add1(20'h15850, 4'h0, mk(1,1,0,0,0,1,2'd2,2'd2,3'd0,2'd1,2'd2));
        add1(20'h15850, 4'h0, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd1,2'd2));
        add1(20'h15850, 4'h0, mk(0,0,0,0,0,0,2'd1,2'd0,3'd0,2'd1,2'd2));
        add1(20'h15850, 4'h0, mk(0,0,0,0,1,0,2'd0,2'd0,3'd0,2'd1,2'd2));
        // STR (AL) writes memory
        add1(20'hE5810, 4'h0, mk(1,1,0,0,0,1,2'd2,2'd2,3'd0,2'd1,2'd2));
        add1(20'hE5810, 4'h0, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd1,2'd2));
        add1(20'hE5810, 4'h0, mk(0,0,0,0,0,0,2'd1,2'd0,3'd0,2'd1,2'd2));
        add1(20'hE5810, 4'h0, mk(0,0,0,1,1,0,2'd0,2'd0,3'd0,2'd1,2'd2));
        // EOR: decoded only when ALUCTRL_W=3
        add1(20'hE0221, 4'h0, mk(1,1,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hE0221, 4'h0, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add (20'hE0221, 4'h0, mk(0,0,0,0,0,0,2'd0,2'd0,3'd4,2'd0,2'd0),
                              mk(0,0,0,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0));
        add (20'hE0221, 4'h0, mk(0,0,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0),
                              mk(0,0,0,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0));
        // ADD immediate (EXECI)
        add1(20'hE2811, 4'h0, mk(1,1,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hE2811, 4'h0, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hE2811, 4'h0, mk(0,0,0,0,0,0,2'd1,2'd0,3'd0,2'd0,2'd0));
        add1(20'hE2811, 4'h0, mk(0,0,1,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0));
        // ADD R15: write goes to PC instead of register file
        add1(20'hE082F, 4'h0, mk(1,1,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hE082F, 4'h0, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hE082F, 4'h0, mk(0,0,0,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0));
        add1(20'hE082F, 4'h0, mk(1,0,0,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0));
        // Undefined op class
        add1(20'hEC000, 4'h0, mk(1,1,0,0,0,1,2'd2,2'd2,3'd0,2'd3,2'd0));
        add1(20'hEC000, 4'h0, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd3,2'd0));
        add1(20'hEC000, 4'h0, mk(0,0,0,0,0,0,2'd0,2'd0,3'd0,2'd3,2'd0));
        // Cond=1111 never executes
        add1(20'hF0821, 4'h0, mk(1,1,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hF0821, 4'h0, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        add1(20'hF0821, 4'h0, mk(0,0,0,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0));
        add1(20'hF0821, 4'h0, mk(0,0,0,0,0,0,2'd0,2'd0,3'd0,2'd0,2'd0));

        // Reset state
        reset = 1'b0;
        instr = 20'h0;
        flags = 4'h0;
        @(negedge clk);
        #1;
        check("reset_w3", 0, v3, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        check("reset_w2", 0, v2, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd0,2'd0));
        @(negedge clk);
        reset = 1'b1;

        // One vector per cycle: drive on the falling edge, compare 1ns later
        for (int i = 0; i < vecs.size(); i++) begin
            instr = vecs[i].instr;
            flags = vecs[i].flags;
            #1;
            check("vec_w3", i, v3, vecs[i].e3);
            check("vec_w2", i, v2, vecs[i].e2);
            @(negedge clk);
        end

        // Asynchronous reset in MEMRD (Z=1 left behind by CMP above)
        instr = 20'hE5910;                 // FETCH
        @(negedge clk);                    // DECODE
        @(negedge clk);                    // MEMADR
        @(negedge clk);                    // MEMRD
        #1;
        check1("memrd_adrsrc", adr3, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_w3", 0, v3, mk(0,0,0,0,0,1,2'd2,2'd2,3'd0,2'd1,2'd2));
        @(negedge clk);
        reset = 1'b1;
        instr = 20'h0A000;                 // BEQ after reset: flags must be clear
        #1;
        check1("release_irwrite", irw3, 1'b1);
        check1("release_pcwrite", pcw3, 1'b1);
        @(negedge clk);                    // DECODE
        @(negedge clk);                    // BRANCH
        #1;
        check1("beq_after_reset_w3", pcw3, 1'b0);
        check1("beq_after_reset_w2", pcw2, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter ALUCTRL_W, default 3, ALUControl width; legal values 2 (ADD/SUB/AND/ORR only) or 3 (adds EOR).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Instr  input  20  instruction bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]; held stable by datapath IR after FETCH.
REQ-005 ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle.
REQ-006 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA  output  1 each  datapath enables/selects.
REQ-007 RegSrc, ImmSrc, ALUSrcB, ResultSrc  output  2 each  datapath selects.
REQ-008 ALUControl  output  ALUCTRL_W  ALU op: ADD=0, SUB=1, AND=2, ORR=3, EOR=4.

Function
REQ-009 Main FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, UNKNOWN; 4-bit encoding in shared package.
REQ-010 Transitions: FETCH->DECODE; DECODE->MEMADR (Op=01), EXECR (Op=00, Funct[5]=0), EXECI (Op=00, Funct[5]=1), BRANCH (Op=10), UNKNOWN (Op=11).
REQ-011 MEMADR->MEMRD if Funct[0]=1, else MEMWR; MEMRD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN->FETCH.
REQ-012 Latency: data-processing 4 cycles, LDR 5, STR 4, B 3, undefined 3.
REQ-013 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALU ADD, ResultSrc=10, IRWrite=1, PCWrite=1 unconditionally.
REQ-014 DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. MEMADR and BRANCH: ALUSrcA=0, ALUSrcB=01, ADD; BRANCH also ResultSrc=10.
REQ-015 MEMRD/MEMWR: AdrSrc=1, ResultSrc=00; MEMWR asserts MemW. MEMWB: ResultSrc=01, RegW. ALUWB: ResultSrc=00, RegW unless command is CMP.
REQ-016 EXECR: ALUSrcA=0, ALUSrcB=00; EXECI: ALUSrcA=0, ALUSrcB=01; both use ALU decoder.
REQ-017 ALU decoder (EXECR/EXECI only; elsewhere ADD, FlagW=00) on Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP->SUB, 0001 EOR (ALUCTRL_W=3 only); other codes -> ADD with RegW and FlagW suppressed.
REQ-018 FlagW: Funct[0]=1 or CMP -> ADD/SUB/CMP 2'b11, AND/ORR/EOR 2'b10; else 2'b00.
REQ-019 ImmSrc=Op; RegSrc[0]=(Op=10), RegSrc[1]=(Op=01); held constant for all states of an instruction.
REQ-020 Condition evaluated from Cond and registered flags in DECODE, latched into CondExR, used for rest of instruction; flag updates within the instruction do not alter CondExR.
REQ-021 Conditions: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL per ARM; Cond=1111 -> false.
REQ-022 Flag register {N,Z} written from ALUFlags when FlagW[1]&CondExR, {C,V} when FlagW[0]&CondExR, on rising edge in EXEC state.
REQ-023 PCS = Branch | (RegW & Rd=1111); PCWrite = FETCH | (PCS & CondExR); RegWrite = RegW & CondExR & ~(Rd=1111); MemWrite = MemW & CondExR.
REQ-024 Write to R15 in ALUWB/MEMWB drives PCWrite instead of RegWrite.

Reset
REQ-025 reset low forces state FETCH, flags 0000, CondExR 0 immediately, asynchronously, including mid-instruction; deassertion synchronous to clk.
REQ-026 During reset, outputs equal FETCH decode except PCWrite=0 and IRWrite=0.

Configuration
REQ-027 MC_CTRL_STATE_OUT_EN defined: extra output State (4 bits, current FSM encoding). Not defined: port absent, behaviour otherwise identical.

Structure
REQ-028 Shared package mc_ctrl_pkg: state encodings, ALUControl codes, Cond codes, Funct command codes.
REQ-029 One sub-module, mc_condlogic: flag registers, CondExR, condition check, write gating; FSM and decoders in top.

Verification
REQ-030 Reset low during MEMRD -> state FETCH next sample, flags 0000; after release, first edge IRWrite=1, PCWrite=1.
REQ-031 Instr=0xE0821 (ADD R1,R2,R3) -> FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in ALUWB, ALUControl=0.
REQ-032 Instr=0xE5910 (LDR R0,[R1,#4]) -> 5 cycles; MEMRD AdrSrc=1; MEMWB RegWrite=1, ResultSrc=01.
REQ-033 Instr=0xE0500 (SUBS) with ALUFlags=0100 in EXECR -> Z=1; then Instr=0x0A000 (BEQ) -> PCWrite=1 in BRANCH; repeat with ALUFlags=0000 -> PCWrite=0.
REQ-034 Z=1, Instr=0x15850 (STRNE) -> MemWrite=0 in MEMWR, return to FETCH.
REQ-035 ALUCTRL_W=3, Instr=0xE0221 (EOR) -> ALUControl=4; ALUCTRL_W=2 -> ALUControl=0, RegWrite=0 in ALUWB.
